// File: rtl/bcd_key_entry_reg.sv
// Multi-digit decimal key entry: one evaluation per press, BCD shift-in accumulator,
// sticky first-cause error reporting and synchronous clear.
module bcd_key_entry_reg #(
    parameter int DIGITS   = 4,
    parameter int PRIORITY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [9:0]            key,
    input  logic                  key_valid,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [3:0]            last_digit,
    output logic [3:0]            digit_count,
    output logic                  full,
    output logic                  key_accept,
    output logic                  err,
    output logic [1:0]            err_code
);
    localparam int        W        = 4 * DIGITS;
    localparam logic [3:0] DIGITS_L = 4'(DIGITS);

    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

    state_t       state_reg, state_next;
    logic [W-1:0] bcd_reg, bcd_next;
    logic [3:0]   last_reg, last_next;
    logic [3:0]   count_reg, count_next;
    logic         full_reg, full_next;
    logic         accept_reg, accept_next;
    logic         err_reg, err_next;
    logic [1:0]   code_reg, code_next;

    logic [3:0]   enc_digit;
    logic         no_key, multi_hot;
    logic         press, press_accept, press_err;
    logic [1:0]   press_code;
    logic [W-1:0] shifted;

    // Highest set index wins; for a one-hot key this is simply its index.
    always_comb begin
        enc_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key[i]) enc_digit = 4'(i);
        end
    end

    assign no_key    = (key == 10'd0);
    assign multi_hot = |(key & (key - 10'd1));

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_shift
            if (gi == 0) begin : g_lsd
                assign shifted[3:0] = enc_digit;
            end else begin : g_upper
                assign shifted[4*gi +: 4] = bcd_reg[4*(gi-1) +: 4];
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic; clear with the key still down parks in HELD so it is not re-captured
    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = key_valid ? HELD : IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (key_valid)  state_next = HELD;
                HELD:    if (!key_valid) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic: evaluate a press on the IDLE->HELD edge only
    always_comb begin
        press        = (state_reg == IDLE) && key_valid && !clear;
        press_accept = 1'b0;
        press_err    = 1'b0;
        press_code   = 2'b00;
        if (press) begin
            if (no_key) begin
                press_err  = 1'b1;
                press_code = 2'b01;
            end else if (multi_hot && (PRIORITY == 0)) begin
                press_err  = 1'b1;
                press_code = 2'b10;
            end else if (full_reg) begin
                press_err  = 1'b1;
                press_code = 2'b11;
            end else begin
                press_accept = 1'b1;
            end
        end
    end

    always_comb begin
        bcd_next    = bcd_reg;
        last_next   = last_reg;
        count_next  = count_reg;
        accept_next = 1'b0;
        err_next    = err_reg;
        code_next   = code_reg;
        if (clear) begin
            bcd_next   = '0;
            last_next  = 4'd0;
            count_next = 4'd0;
            err_next   = 1'b0;
            code_next  = 2'b00;
        end else begin
            if (press_accept) begin
                bcd_next    = shifted;
                last_next   = enc_digit;
                count_next  = count_reg + 4'd1;
                accept_next = 1'b1;
            end
            // Only the first error cause is kept until clear or reset
            if (press_err && !err_reg) code_next = press_code;
            err_next = err_reg | press_err;
        end
        full_next = (count_next == DIGITS_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_reg    <= '0;
            last_reg   <= 4'd0;
            count_reg  <= 4'd0;
            full_reg   <= 1'b0;
            accept_reg <= 1'b0;
            err_reg    <= 1'b0;
            code_reg   <= 2'b00;
        end else begin
            bcd_reg    <= bcd_next;
            last_reg   <= last_next;
            count_reg  <= count_next;
            full_reg   <= full_next;
            accept_reg <= accept_next;
            err_reg    <= err_next;
            code_reg   <= code_next;
        end
    end

    assign bcd_out     = bcd_reg;
    assign last_digit  = last_reg;
    assign digit_count = count_reg;
    assign full        = full_reg;
    assign key_accept  = accept_reg;
    assign err         = err_reg;
    assign err_code    = code_reg;
endmodule
